// File: rtl/sa_ram_rwsp_param_if.sv
// Access bus of the parametrised 1R/1W systolic-array buffer RAM.
// The master drives read/write requests; the slave (the RAM) returns
// registered read data, its valid flag and the status outputs.
interface sa_ram_rwsp_param_if #(
    parameter int AW    = 3,
    parameter int WIDTH = 257,
    parameter int LANES = 1
) ();
    logic [AW-1:0]    ra;
    logic             re;
    logic             ore;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic [AW-1:0]    wa;
    logic             we;
    logic [LANES-1:0] wmask;
    logic [WIDTH-1:0] di;
    logic             init_done;
    logic             addr_err;
    logic [31:0]      pwrbus_ram_pd;

    modport master (
        output ra, re, ore, wa, we, wmask, di, pwrbus_ram_pd,
        input  dout, dout_vld, init_done, addr_err
    );

    modport slave (
        input  ra, re, ore, wa, we, wmask, di, pwrbus_ram_pd,
        output dout, dout_vld, init_done, addr_err
    );
endinterface

// File: rtl/sa_ram_rwsp_param.sv
// Parametrised 1-read/1-write synchronous RAM model for systolic-array buffers.
// Registered read address (ra_d) feeding an output register (dout_r), per-lane
// write mask, optional same-cycle write->read bypass, a power-on clear sweep
// and a valid flag that follows the read data.
module sa_ram_rwsp_param #(
    parameter int DEPTH      = 8,
    parameter int WIDTH      = 257,
    parameter int AW         = 3,
    parameter int LANES      = 1,
    parameter int BYPASS_EN  = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    sa_ram_rwsp_param_if.slave   bus
);

    // Lane width rounds up, so the last lane covers whatever bits remain.
    localparam int LW = (WIDTH + LANES - 1) / LANES;
    // Index width of the storage array; addresses are range-checked before use.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t           state;
    logic [AW-1:0]    sweep_ptr;
    logic [AW-1:0]    ra_d;
    logic             rd_armed;
    logic [WIDTH-1:0] dout_r;
    logic             dout_vld;
    logic             init_done;
    logic             addr_err;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             run;
    logic             ra_ok;
    logic             wa_ok;
    logic             ra_d_ok;
    logic             wr_ok;
    logic             hit;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] wr_old;
    logic [WIDTH-1:0] wr_word;
    logic [WIDTH-1:0] dout_next;
    logic             unused_pwr;

    // Bits of new_w selected by mask replace those of old_w; the rest keep old_w.
    function automatic logic [WIDTH-1:0] lane_merge(
        input logic [WIDTH-1:0] old_w,
        input logic [WIDTH-1:0] new_w,
        input logic [WIDTH-1:0] mask
    );
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    // The power-down bus has no effect in this behavioural model.
    assign unused_pwr = ^bus.pwrbus_ram_pd;

    assign run     = (state == ST_RUN) && !rst;
    assign ra_ok   = ({1'b0, bus.ra} < DEPTH_X);
    assign wa_ok   = ({1'b0, bus.wa} < DEPTH_X);
    assign ra_d_ok = ({1'b0, ra_d} < DEPTH_X);
    assign wr_ok   = run && bus.we && wa_ok;
    assign hit     = wr_ok && bus.ore && (bus.wa == ra_d);

    // Expand the per-lane write mask to one enable bit per data bit.
    always_comb begin
        bit_mask = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int b = 0; b < LW; b++) begin
                if (l * LW + b < WIDTH) begin
                    bit_mask[l * LW + b] = bus.wmask[l];
                end
            end
        end
    end

    // Array reads for the output register and for the masked write merge.
    always_comb begin
        rd_word = '0;
        wr_old  = '0;
        if (ra_d_ok) begin
            rd_word = mem[ra_d[IW-1:0]];
        end
        if (wa_ok) begin
            wr_old = mem[bus.wa[IW-1:0]];
        end
        wr_word = lane_merge(wr_old, bus.di, bit_mask);
        // On a collision the bypass path shows the word as it will be after the write.
        if ((BYPASS_EN != 0) && hit) begin
            dout_next = lane_merge(rd_word, bus.di, bit_mask);
        end else begin
            dout_next = rd_word;
        end
    end

    // Storage: the clear sweep owns the array until it finishes, then masked writes.
    always_ff @(posedge clk) begin
        if (!rst && (state == ST_SWEEP)) begin
            mem[sweep_ptr[IW-1:0]] <= '0;
        end else if (wr_ok) begin
            mem[bus.wa[IW-1:0]] <= wr_word;
        end
    end

    // Control FSM plus the read-address, output and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= (INIT_CLEAR != 0) ? ST_SWEEP : ST_RUN;
            sweep_ptr <= '0;
            init_done <= 1'b0;
            ra_d      <= '0;
            rd_armed  <= 1'b0;
            dout_r    <= '0;
            dout_vld  <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            case (state)
                ST_SWEEP: begin
                    addr_err <= 1'b0;
                    if (sweep_ptr == LAST) begin
                        state     <= ST_RUN;
                        sweep_ptr <= '0;
                        init_done <= 1'b1;
                    end else begin
                        sweep_ptr <= sweep_ptr + 1'b1;
                    end
                end
                default: begin
                    init_done <= 1'b1;
                    if (bus.re) begin
                        ra_d     <= bus.ra;
                        rd_armed <= 1'b1;
                    end
                    if (bus.ore) begin
                        dout_r   <= dout_next;
                        dout_vld <= rd_armed;
                    end
                    addr_err <= (bus.re && !ra_ok) || (bus.we && !wa_ok);
                end
            endcase
        end
    end

    assign bus.dout      = dout_r;
    assign bus.dout_vld  = dout_vld;
    assign bus.init_done = init_done;
    assign bus.addr_err  = addr_err;

endmodule

// File: tb/tb_sa_ram_rwsp_param.sv
// Directed bench for sa_ram_rwsp_param: two 5x16 two-lane instances that
// differ only in bypass, plus a default-size 8x257 instance without clear sweep.
module tb_sa_ram_rwsp_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  ra;
    logic [2:0]  wa;
    logic        re;
    logic        ore;
    logic        we;
    logic [1:0]  wmask;
    logic [15:0] di;
    logic [31:0] pwr;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sa_ram_rwsp_param_if #(.AW(3), .WIDTH(16),  .LANES(2)) ifa ();
    sa_ram_rwsp_param_if #(.AW(3), .WIDTH(16),  .LANES(2)) ifb ();
    sa_ram_rwsp_param_if #(.AW(3), .WIDTH(257), .LANES(1)) ifc ();

    assign ifa.ra = ra;  assign ifa.re = re;  assign ifa.ore = ore;
    assign ifa.wa = wa;  assign ifa.we = we;  assign ifa.wmask = wmask;
    assign ifa.di = di;  assign ifa.pwrbus_ram_pd = pwr;

    assign ifb.ra = ra;  assign ifb.re = re;  assign ifb.ore = ore;
    assign ifb.wa = wa;  assign ifb.we = we;  assign ifb.wmask = wmask;
    assign ifb.di = di;  assign ifb.pwrbus_ram_pd = pwr;

    assign ifc.ra = ra;  assign ifc.re = re;  assign ifc.ore = ore;
    assign ifc.wa = wa;  assign ifc.we = we;  assign ifc.wmask = wmask[0];
    assign ifc.di = {1'b1, 240'h0, di};
    assign ifc.pwrbus_ram_pd = pwr;

    sa_ram_rwsp_param #(.DEPTH(5), .WIDTH(16), .AW(3), .LANES(2),
                        .BYPASS_EN(1), .INIT_CLEAR(1))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));

    sa_ram_rwsp_param #(.DEPTH(5), .WIDTH(16), .AW(3), .LANES(2),
                        .BYPASS_EN(0), .INIT_CLEAR(1))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    sa_ram_rwsp_param #(.DEPTH(8), .WIDTH(257), .AW(3), .LANES(1),
                        .BYPASS_EN(1), .INIT_CLEAR(0))
        dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

    task automatic chk(input string tag, input logic [256:0] got, input logic [256:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] m);
        we = 1'b1; wa = a; di = d; wmask = m;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        re = 1'b1; ra = a;
        tick();
        re = 1'b0; ore = 1'b1;
        tick();
        ore = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ra = '0; wa = '0; re = 1'b0; ore = 1'b0; we = 1'b0;
        wmask = '0; di = '0; pwr = 32'h0;
        tick(); tick(); tick();

        // reset state
        chk("rst_init_a", ifa.init_done, 0);
        chk("rst_init_c", ifc.init_done, 0);
        chk("rst_dout_a", ifa.dout, 0);
        chk("rst_vld_a",  ifa.dout_vld, 0);
        chk("rst_err_a",  ifa.addr_err, 0);

        // clear sweep: init_done rises exactly DEPTH edges after release
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("sweep_init_a_%0d", i), ifa.init_done, (i == 5));
            chk($sformatf("sweep_init_b_%0d", i), ifb.init_done, (i == 5));
            if (i == 1) chk("noclear_init_c", ifc.init_done, 1);
        end

        // every word reads back zero after the sweep
        for (int k = 0; k < 5; k++) begin
            rd(3'(k));
            chk($sformatf("clr_a_%0d", k), ifa.dout, 0);
            chk($sformatf("clr_b_%0d", k), ifb.dout, 0);
        end
        chk("clr_vld_a", ifa.dout_vld, 1);

        // write then read
        wr(3'd2, 16'hA5A5, 2'b11);
        rd(3'd2);
        chk("wr_rd_a",   ifa.dout, 16'hA5A5);
        chk("wr_rd_vld", ifa.dout_vld, 1);
        chk("wr_rd_c",   ifc.dout, {1'b1, 240'h0, 16'hA5A5});

        // lane mask
        wr(3'd3, 16'h1234, 2'b11);
        wr(3'd3, 16'hABCD, 2'b10);
        rd(3'd3);
        chk("mask_a", ifa.dout, 16'hAB34);
        chk("mask_b", ifb.dout, 16'hAB34);
        wr(3'd3, 16'hFFFF, 2'b00);
        rd(3'd3);
        chk("mask_noop_a", ifa.dout, 16'hAB34);

        // collision, full mask
        wr(3'd1, 16'h0001, 2'b11);
        re = 1'b1; ra = 3'd1;
        tick();
        re = 1'b0;
        ore = 1'b1; we = 1'b1; wa = 3'd1; di = 16'h00FF; wmask = 2'b11;
        tick();
        chk("coll_byp_a",   ifa.dout, 16'h00FF);
        chk("coll_nobyp_b", ifb.dout, 16'h0001);
        we = 1'b0;
        tick();
        chk("coll_next_b", ifb.dout, 16'h00FF);
        chk("coll_next_a", ifa.dout, 16'h00FF);

        // collision, upper lane only
        we = 1'b1; wa = 3'd1; di = 16'hAB00; wmask = 2'b10;
        tick();
        chk("coll_lane_a", ifa.dout, 16'hABFF);
        chk("coll_lane_b", ifb.dout, 16'h00FF);
        we = 1'b0;
        tick();
        chk("coll_lane_next_b", ifb.dout, 16'hABFF);
        ore = 1'b0;

        // out-of-range write and read
        wr(3'd6, 16'hFFFF, 2'b11);
        chk("oor_wr_err_a", ifa.addr_err, 1);
        chk("oor_wr_err_c", ifc.addr_err, 0);
        tick();
        chk("oor_wr_err_clr", ifa.addr_err, 0);
        rd(3'd2);
        chk("oor_wr_keep2", ifa.dout, 16'hA5A5);
        rd(3'd1);
        chk("oor_wr_keep1", ifa.dout, 16'hABFF);
        re = 1'b1; ra = 3'd7;
        tick();
        chk("oor_rd_err", ifa.addr_err, 1);
        re = 1'b0; ore = 1'b1;
        tick();
        ore = 1'b0;
        chk("oor_rd_dout", ifa.dout, 0);
        chk("oor_rd_err_clr", ifa.addr_err, 0);

        // reset two cycles into a sweep, with accesses held active throughout
        rst = 1'b1;
        tick();
        chk("rst2_init_c", ifc.init_done, 0);
        rst = 1'b0;
        we = 1'b1; wa = 3'd0; di = 16'hFFFF; wmask = 2'b11;
        re = 1'b1; ra = 3'd2; ore = 1'b1;
        tick(); tick();
        chk("part_init_a", ifa.init_done, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("resweep_init_%0d", i), ifa.init_done, (i == 5));
            chk($sformatf("resweep_dout_%0d", i), ifa.dout, 0);
            chk($sformatf("resweep_vld_%0d", i), ifa.dout_vld, 0);
        end
        we = 1'b0; re = 1'b0; ore = 1'b0;
        rd(3'd0);
        chk("resweep_w0", ifa.dout, 0);
        rd(3'd2);
        chk("resweep_w2", ifa.dout, 0);
        chk("resweep_w2_b", ifb.dout, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
